// File: rtl/timer_pkg.sv
// Shared definitions for the timer blocks: FSM state encoding and
// the periodic/one-shot mode constants.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ONE_SHOT = 1'b0;
  localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/countdown_timer.sv
// Loadable modulo down-counter used as a programmable interval/one-shot
// timer; counts reload value down to 0 on prescaler ticks and pulses tc.
//
// state | meaning
// IDLE  | stopped, count held, ticks ignored
// RUN   | counting down one step per tick
// DONE  | one-shot expired, count parked at 0 until start or load
module countdown_timer
  import timer_pkg::*;
#(
  parameter int            W            = 16,
  parameter logic [W-1:0]  RESET_RELOAD = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic          start,
  input  logic          stop,
  input  logic          periodic,
  output logic [W-1:0]  count,
  output logic          tc,
  output logic          running
);

  state_t         state, state_n;
  logic [W-1:0]   reload_reg, reload_n;
  logic [W-1:0]   count_n;
  logic           tc_n;

  // Strobes are mutually exclusive by priority: load > stop > start > tick.
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    tc_n     = 1'b0;
    if (load) begin
      reload_n = load_val;
      count_n  = load_val;
      if (state == DONE) state_n = IDLE;
    end else if (stop) begin
      if (state == RUN) state_n = IDLE;
    end else if (start) begin
      count_n = reload_reg;
      state_n = RUN;
    end else if (tick && (state == RUN)) begin
      if (count != '0) begin
        count_n = count - W'(1);
      end else begin
        tc_n = 1'b1;
        if (periodic == PERIODIC) count_n = reload_reg;
        else                      state_n = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= RESET_RELOAD;
      tc         <= 1'b0;
      running    <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      tc         <= tc_n;
      running    <= (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a table of stimulus/expected records
// followed by hand-written gap-tick and reset-during-terminal sequences.
module tb_countdown_timer;

  localparam int           W  = 16;
  localparam logic [W-1:0] RR = 16'd7;

  logic          clk = 1'b0;
  logic          reset, tick, load, start, stop, periodic;
  logic [W-1:0]  load_val;
  logic [W-1:0]  count;
  logic          tc, running;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic          rst;
    logic          ld;
    logic [W-1:0]  lv;
    logic          st;
    logic          sp;
    logic          tk;
    logic          per;
    logic [W-1:0]  ec;
    logic          etc;
    logic          er;
  } vec_t;

  vec_t vecs[$];

  countdown_timer #(.W(W), .RESET_RELOAD(RR)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .periodic(periodic),
    .count(count), .tc(tc), .running(running)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic ld, logic [W-1:0] lv, logic st,
                              logic sp, logic tk, logic per,
                              logic [W-1:0] ec, logic etc, logic er);
    vec_t v;
    v.rst = rst; v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.tk = tk;
    v.per = per; v.ec = ec; v.etc = etc; v.er = er;
    return v;
  endfunction

  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    reset = v.rst; load = v.ld; load_val = v.lv; start = v.st;
    stop = v.sp; tick = v.tk; periodic = v.per;
    @(posedge clk);
    #1;
    tests_run++;
    if (count !== v.ec || tc !== v.etc || running !== v.er) begin
      tests_failed++;
      $display("FAIL %s: got count=%0d tc=%0b running=%0b, expected count=%0d tc=%0b running=%0b",
               name, count, tc, running, v.ec, v.etc, v.er);
    end
  endtask

  initial begin
    int ticks_seen;
    logic tk;
    reset = 1'b1; load = 1'b0; load_val = '0; start = 1'b0;
    stop = 1'b0; tick = 1'b0; periodic = 1'b0;

    //                rst ld lv   st sp tk per  count tc run
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 0,   0,    0, 0)); // reset state
    vecs.push_back(mk(0, 0, 0,   1, 0, 0, 0,   RR,   0, 1)); // reset reload value
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 0,   6,    0, 1));
    vecs.push_back(mk(1, 0, 0,   0, 0, 1, 0,   0,    0, 0)); // reset mid-RUN
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 0,   0,    0, 0));
    vecs.push_back(mk(0, 1, 3,   0, 0, 0, 0,   3,    0, 0)); // one-shot
    vecs.push_back(mk(0, 0, 0,   1, 0, 0, 0,   3,    0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 0,   2,    0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 0,   1,    0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 0,   0,    0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 0,   0,    1, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 0,   0,    0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 0,   0,    0, 0)); // tick in DONE
    vecs.push_back(mk(0, 1, 2,   0, 0, 0, 0,   2,    0, 0)); // periodic
    vecs.push_back(mk(0, 0, 0,   1, 0, 0, 1,   2,    0, 1));
    for (int p = 0; p < 3; p++) begin
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1,   1,    0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1,   0,    0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1,   2,    1, 1));
    end
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 1,   1,    0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 1, 1, 1,   1,    0, 0)); // stop+start+tick
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 1,   1,    0, 0)); // tick in IDLE
    vecs.push_back(mk(0, 0, 0,   1, 0, 0, 1,   2,    0, 1));
    vecs.push_back(mk(0, 1, 9,   0, 0, 1, 1,   9,    0, 1)); // load+tick
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 1,   8,    0, 1));
    vecs.push_back(mk(0, 1, 0,   0, 0, 0, 1,   0,    0, 1)); // zero reload
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 1,   0,    1, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 1,   0,    1, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 1,   0,    1, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 1,   0,    0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 1, 0, 1,   0,    0, 0));
    vecs.push_back(mk(0, 1, 4,   0, 0, 0, 0,   4,    0, 0)); // restart in RUN
    vecs.push_back(mk(0, 0, 0,   1, 0, 0, 0,   4,    0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 0,   3,    0, 1));
    vecs.push_back(mk(0, 0, 0,   1, 0, 1, 0,   4,    0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 0,   3,    0, 1));

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i], $sformatf("vec%0d", i));

    // Ticks every third cycle: count moves only on ticks, tc after the 6th.
    step(mk(0, 0, 0, 0, 1, 0, 0, 3, 0, 0), "gap_stop");
    step(mk(0, 1, 5, 0, 0, 0, 0, 5, 0, 0), "gap_load");
    step(mk(0, 0, 0, 1, 0, 0, 0, 5, 0, 1), "gap_start");
    ticks_seen = 0;
    for (int k = 0; k < 18; k++) begin
      tk = (k % 3 == 2);
      if (tk) ticks_seen++;
      step(mk(0, 0, 0, 0, 0, tk, 0,
              (ticks_seen < 6) ? W'(5 - ticks_seen) : W'(0),
              tk && (ticks_seen == 6),
              ticks_seen < 6),
           $sformatf("gap_cyc%0d", k));
    end

    // Reset on the cycle of a terminal tick suppresses the pending tc.
    step(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0), "rst_tc_load");
    step(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1), "rst_tc_start");
    step(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0), "rst_tc_reset");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "rst_tc_after");
    step(mk(0, 0, 0, 1, 0, 0, 1, RR, 0, 1), "rst_tc_reload");
    step(mk(0, 0, 0, 0, 0, 1, 1, RR - 16'd1, 0, 1), "rst_tc_tick");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
